// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester round-robin arbiter in front of a single-outstanding memory
// port. Requester 0 is the cpu, requester 1 is the loader. A winner is picked
// in IDLE, its command is latched and held on the memory port for the whole
// BUSY phase, and the transaction ends either on mem_ready or after TIMEOUT
// BUSY cycles without it (abort, flagged with err).
//
// Parameters
//   TIMEOUT    BUSY cycles without mem_ready before abort; 0 disables timeout.
//
// Ports
//   clock              single clock, rising edge
//   reset              asynchronous, active-high reset
//   req0/req1          access requests
//   rw0/rw1            direction per requester: 1 = read, 0 = write
//   addr0/addr1        access addresses (32 bit)
//   wdata0/wdata1      write data (32 bit)
//   gnt0/gnt1          registered; high while that requester owns the bus
//   done0/done1        one-cycle completion pulse
//   err0/err1          one-cycle timeout pulse, coincident with done
//   rdata              read data of the last completed read
//   mem_valid/mem_rw/mem_addr/mem_wdata   memory command (held during BUSY)
//   mem_ready/mem_rdata                   memory completion and read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        rw0,
  input  logic        rw1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic        mem_valid,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // The counter only has to reach TIMEOUT-1 (the value seen during the last
  // allowed BUSY cycle).
  localparam int CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CNT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST_V = CW'(CNT_LAST);
  localparam bit TIMEOUT_EN = (TIMEOUT > 0);

  state_t        state_q,     state_d;
  logic          last_q,      last_d;      // 1: requester 1 was granted last
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          gnt0_q,      gnt0_d;
  logic          gnt1_q,      gnt1_d;
  logic          done0_q,     done0_d;
  logic          done1_q,     done1_d;
  logic          err0_q,      err0_d;
  logic          err1_q,      err1_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_rw_q,    mem_rw_d;
  logic [31:0]   mem_addr_q,  mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   rdata_q,     rdata_d;

  logic          pick1;     // requester 1 wins this arbitration
  logic          finish;    // transaction ends on this edge
  logic          timed_out; // transaction ends by abort on this edge

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    mem_valid_d = mem_valid_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    pick1       = 1'b0;
    finish      = 1'b0;
    timed_out   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // mem_ready is deliberately not looked at here.
        if (req0 || req1) begin
          // Requester 1 wins when alone, or when both ask and 0 went last.
          pick1       = req1 && (!req0 || !last_q);
          gnt0_d      = !pick1;
          gnt1_d      = pick1;
          mem_valid_d = 1'b1;
          mem_rw_d    = pick1 ? rw1    : rw0;
          mem_addr_d  = pick1 ? addr1  : addr0;
          mem_wdata_d = pick1 ? wdata1 : wdata0;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end

      BUSY: begin
        // mem_ready is checked first so it wins over a coincident timeout.
        if (mem_ready) begin
          finish = 1'b1;
          if (mem_rw_q) begin
            rdata_d = mem_rdata;
          end
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST_V)) begin
          finish    = 1'b1;
          timed_out = 1'b1;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + CW'(1);
        end

        if (finish) begin
          done0_d     = gnt0_q;
          done1_d     = gnt1_q;
          err0_d      = timed_out && gnt0_q;
          err1_d      = timed_out && gnt1_q;
          last_d      = gnt1_q;
          gnt0_d      = 1'b0;
          gnt1_d      = 1'b0;
          mem_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: reset is asynchronous and clears every flop, so a transaction in
  // flight is dropped immediately and leaves no done/err pulse behind.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;  // requester 0 gets first priority after reset
      cnt_q       <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata     = rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. Directed scenarios plus randomized
// traffic, all compared every cycle against a transaction-level model that
// counts BUSY cycles with plain integers.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1, rw0, rw1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata;
  logic        mem_valid, mem_rw;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  always #5 clock = ~clock;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .rw0       (rw0),
    .rw1       (rw1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .err0      (err0),
    .err1      (err1),
    .rdata     (rdata),
    .mem_valid (mem_valid),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one transaction at a time, BUSY length as an integer.
  // ---------------------------------------------------------------------------
  bit          m_busy;
  int          m_owner;
  int          m_cycles;   // BUSY cycles elapsed in the current transaction
  int          m_last;     // requester granted last
  bit          m_rw;
  logic [31:0] m_addr, m_wdata, m_rdata;
  bit          m_done [2];
  bit          m_err  [2];

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_cycles = 0; m_last = 1;
    m_rw = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    m_done = '{0, 0}; m_err = '{0, 0};
  endtask

  task automatic model_edge();
    int w;
    m_done = '{0, 0}; m_err = '{0, 0};
    if (m_busy) begin
      m_cycles++;
      if (mem_ready) begin
        m_done[m_owner] = 1;
        if (m_rw) m_rdata = mem_rdata;
        m_last = m_owner;
        m_busy = 0;
      end else if (TIMEOUT > 0 && m_cycles == TIMEOUT) begin
        m_done[m_owner] = 1;
        m_err[m_owner]  = 1;
        m_last = m_owner;
        m_busy = 0;
      end
    end else if (req0 || req1) begin
      if (req0 && req1) w = 1 - m_last;
      else w = req0 ? 0 : 1;
      m_busy = 1; m_owner = w; m_cycles = 0;
      m_rw    = (w == 0) ? rw0    : rw1;
      m_addr  = (w == 0) ? addr0  : addr1;
      m_wdata = (w == 0) ? wdata0 : wdata1;
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".gnt0"},      32'(gnt0),      32'(m_busy && m_owner == 0));
    check({ph, ".gnt1"},      32'(gnt1),      32'(m_busy && m_owner == 1));
    check({ph, ".done0"},     32'(done0),     32'(m_done[0]));
    check({ph, ".done1"},     32'(done1),     32'(m_done[1]));
    check({ph, ".err0"},      32'(err0),      32'(m_err[0]));
    check({ph, ".err1"},      32'(err1),      32'(m_err[1]));
    check({ph, ".mem_valid"}, 32'(mem_valid), 32'(m_busy));
    check({ph, ".mem_rw"},    32'(mem_rw),    32'(m_rw));
    check({ph, ".mem_addr"},  mem_addr,  m_addr);
    check({ph, ".mem_wdata"}, mem_wdata, m_wdata);
    check({ph, ".rdata"},     rdata,     m_rdata);
  endtask

  // Inputs are changed only at the falling edge; outputs are sampled there.
  task automatic cycle(input string ph);
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all(ph);
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    @(negedge clock);
    check_all("reset");
    reset = 0;
  endtask

  initial begin
    int vcnt, dcnt, g1cnt;
    int grants[$];
    logic [31:0] saved;

    idle_inputs();
    do_reset();

    // Single read by requester 0, ready in the 2nd BUSY cycle.
    req0 = 1; rw0 = 1; addr0 = 32'h10;
    vcnt = 0; dcnt = 0; g1cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) req0 = 0;
      mem_ready = (i == 2);
      mem_rdata = (i == 2) ? 32'hDEADBEEF : 32'h0;
      cycle("rd0");
      vcnt += int'(mem_valid); dcnt += int'(done0); g1cnt += int'(gnt1);
    end
    check("rd0.valid_cycles", vcnt, 2);
    check("rd0.done_pulses", dcnt, 1);
    check("rd0.gnt1_seen", g1cnt, 0);
    check("rd0.rdata", rdata, 32'hDEADBEEF);

    // Write by requester 1 that never gets mem_ready: timeout abort.
    req1 = 1; rw1 = 0; addr1 = 32'h20; wdata1 = 32'h55; mem_ready = 0;
    saved = rdata;
    cycle("to1.grant");
    req1 = 0;
    for (int i = 1; i < TIMEOUT; i++) cycle("to1.wait");
    check("to1.err_early", 32'(err1), 32'h0);
    cycle("to1.abort");
    check("to1.done1", 32'(done1), 32'h1);
    check("to1.err1", 32'(err1), 32'h1);
    check("to1.rdata_kept", rdata, saved);
    check("to1.idle", 32'(mem_valid), 32'h0);

    // mem_ready on the last allowed BUSY cycle wins over the timeout.
    req0 = 1; rw0 = 0; addr0 = 32'h30; wdata0 = 32'h77;
    cycle("edge.grant");
    req0 = 0;
    for (int i = 1; i < TIMEOUT; i++) cycle("edge.wait");
    mem_ready = 1;
    cycle("edge.done");
    mem_ready = 0;
    check("edge.done0", 32'(done0), 32'h1);
    check("edge.err0", 32'(err0), 32'h0);
    cycle("edge.idle");

    // Address changes while BUSY are ignored.
    req0 = 1; rw0 = 1; addr0 = 32'h100;
    cycle("hold.grant");
    addr0 = 32'h200; wdata0 = 32'hABCD;
    for (int i = 0; i < 3; i++) begin
      cycle("hold.wait");
      check("hold.mem_addr", mem_addr, 32'h100);
    end
    req0 = 0; mem_ready = 1; mem_rdata = 32'h1234_5678;
    cycle("hold.done");
    mem_ready = 0;
    check("hold.done0", 32'(done0), 32'h1);

    // Asynchronous reset in the middle of a transaction.
    req1 = 1; rw1 = 1; addr1 = 32'h40;
    cycle("arst.grant");
    cycle("arst.busy");
    #2;
    reset = 1;
    #1;
    check("arst.mem_valid", 32'(mem_valid), 32'h0);
    check("arst.gnt1", 32'(gnt1), 32'h0);
    check("arst.mem_addr", mem_addr, 32'h0);
    model_reset();
    @(negedge clock);
    check_all("arst.held");
    reset = 0;
    req0 = 1; req1 = 1; mem_ready = 1; rw0 = 0; addr0 = 32'h50;
    cycle("arst.after");
    check("arst.first_gnt0", 32'(gnt0), 32'h1);

    // Both requesting with memory always ready: strict alternation.
    idle_inputs();
    do_reset();
    req0 = 1; req1 = 1; mem_ready = 1;
    for (int i = 0; i < 8; i++) begin
      cycle("rr");
      if (gnt0) grants.push_back(0);
      if (gnt1) grants.push_back(1);
    end
    check("rr.grant_count", grants.size(), 4);
    for (int i = 0; i < grants.size() && i < 4; i++)
      check($sformatf("rr.grant%0d", i), grants[i], i % 2);

    // Randomized traffic; long ready-low stretches provoke timeouts.
    idle_inputs();
    for (int i = 0; i < 3000; i++) begin
      req0      = ($urandom_range(0, 3) == 0);
      req1      = ($urandom_range(0, 3) == 0);
      rw0       = $urandom_range(0, 1);
      rw1       = $urandom_range(0, 1);
      addr0     = $urandom; addr1  = $urandom;
      wdata0    = $urandom; wdata1 = $urandom;
      mem_ready = ($urandom_range(0, 9) < 2);
      mem_rdata = $urandom;
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
